// File: rtl/clock_pkg.sv
// Shared definitions for the clock-project display path: phase state
// encoding, setting-position codes and 7-segment digit geometry.
package clock_pkg;

   localparam int unsigned DIGIT_W     = 7;
   localparam int unsigned DIGIT_COUNT = 6;
   localparam int unsigned PAIR_W      = 2 * DIGIT_W;
   localparam int unsigned SEG_W       = DIGIT_W * DIGIT_COUNT;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned DIM_W       = 2;
   localparam int unsigned POS_W       = 2;
   localparam int unsigned STATE_W     = 2;

   localparam logic [STATE_W-1:0] IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ON   = 2'd1;
   localparam logic [STATE_W-1:0] OFF  = 2'd2;

   localparam logic [POS_W-1:0] POS_SEC  = 2'd0;
   localparam logic [POS_W-1:0] POS_MIN  = 2'd1;
   localparam logic [POS_W-1:0] POS_HOUR = 2'd2;
   localparam logic [POS_W-1:0] POS_NONE = 2'd3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = IDLE,
      ST_ON   = ON,
      ST_OFF  = OFF
   } state_t;

   // Six digits, digit 0 (sec ones) in the LSBs.
   typedef logic [SEG_W-1:0] seg_t;

endpackage

// File: rtl/blink_digit_blanker_if.sv
// Display-path bundle between the segment encoder, the blanker and the
// FND scan driver.
//   blink            : blinking requested
//   setting_position : 0 sec, 1 min, 2 hour, 3 none
//   i_seg            : six active-high 7-segment digits into the blanker
//   o_seg            : registered, possibly blanked digits out
//   o_blank          : high while the selected pair is in its OFF phase
interface blink_digit_blanker_if;
   import clock_pkg::*;

   logic               blink;
   logic [POS_W-1:0]   setting_position;
   seg_t               i_seg;
   seg_t               o_seg;
   logic               o_blank;

   // Master is the upstream driver / observer side.
   modport master (
      output blink,
      output setting_position,
      output i_seg,
      input  o_seg,
      input  o_blank
   );

   // Slave is the blanker itself.
   modport slave (
      input  blink,
      input  setting_position,
      input  i_seg,
      output o_seg,
      output o_blank
   );

endinterface

// File: rtl/blink_digit_blanker_seg_pair_mask.sv
// Combinational digit-pair mask: zeroes the two digits of the field
// selected by pos_i when blank_i is set. Position 3 selects no field.
//   seg_i   : 42-bit segment vector
//   pos_i   : field selector
//   blank_i : mask enable
//   seg_o_c : masked vector (combinational)
module seg_pair_mask
   import clock_pkg::*;
(
   input  seg_t             seg_i,
   input  logic [POS_W-1:0] pos_i,
   input  logic             blank_i,
   output seg_t             seg_o_c
);

   // Digit d belongs to field d/2; no digit matches position 3.
   always_comb begin
      seg_o_c = seg_i;
      if (blank_i) begin
         for (int d = 0; d < int'(DIGIT_COUNT); d++) begin
            if ((d / 2) == int'(pos_i)) begin
               seg_o_c[d*DIGIT_W +: DIGIT_W] = '0;
            end
         end
      end
   end

endmodule

// File: rtl/blink_digit_blanker.sv
// Setting-mode blink consumer: runs an ON/OFF phase machine on blink_clk
// and blanks the selected digit pair of the display during OFF phases.
// Optional build macro BLINK_BLANKER_DIM_EN: OFF dims the pair to a 25%
// duty via a free-running 2-bit counter instead of blanking it fully.
//   blink_clk : clock
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of blink_digit_blanker_if
// Parameter HALF_PERIOD (1..255): cycles per ON phase and per OFF phase.
module blink_digit_blanker
   import clock_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 8
) (
   input  logic                   blink_clk,
   input  logic                   rst_n,
   blink_digit_blanker_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [POS_W-1:0]  pos_q;
   seg_t              seg_q;
   logic              blank_q;
   logic              mask_en_c;
   seg_t              seg_masked_c;

   // Phase machine: priority-ordered transitions, counter clears on every
   // state change. A position change restarts ON so the new field shows.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      if (!bus.blink || (bus.setting_position == POS_NONE)) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_ON;
         cnt_d   = '0;
      end else if (bus.setting_position != pos_q) begin
         state_d = ST_ON;
         cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
         state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
         cnt_d   = '0;
      end
   end

`ifdef BLINK_BLANKER_DIM_EN
   logic [DIM_W-1:0] dim_cnt_q;

   // Free-running dim phase; the pair is lit on one cycle in four.
   always_ff @(posedge blink_clk or negedge rst_n) begin
      if (!rst_n) begin
         dim_cnt_q <= '0;
      end else begin
         dim_cnt_q <= dim_cnt_q + DIM_W'(1);
      end
   end

   assign mask_en_c = (state_d == ST_OFF) && (dim_cnt_q != '0);
`else
   assign mask_en_c = (state_d == ST_OFF);
`endif

   seg_pair_mask u_mask (
      .seg_i   (bus.i_seg),
      .pos_i   (bus.setting_position),
      .blank_i (mask_en_c),
      .seg_o_c (seg_masked_c)
   );

   // State and outputs registered together from next-state values.
   always_ff @(posedge blink_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pos_q   <= '0;
         seg_q   <= '0;
         blank_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pos_q   <= bus.setting_position;
         seg_q   <= seg_masked_c;
         blank_q <= (state_d == ST_OFF);
      end
   end

   assign bus.o_seg   = seg_q;
   assign bus.o_blank = blank_q;

endmodule

// File: tb/tb_blink_digit_blanker.sv
// Bench for blink_digit_blanker: directed blink scenarios plus a random
// run, all compared against a phase-age reference model.
module tb_blink_digit_blanker;

   localparam int unsigned HP = 8;
   localparam logic [41:0] ALL1 = {42{1'b1}};
   localparam logic [41:0] PAIR1 = 42'h3FFF;

   logic blink_clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   blink_digit_blanker_if bus ();

   blink_digit_blanker #(.HALF_PERIOD(HP)) dut (
      .blink_clk (blink_clk),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   always #5 blink_clk = ~blink_clk;

   // Reference model: age of the current blink run, OFF on odd half-periods.
   bit          m_active;
   int          m_age;
   logic [1:0]  m_pos;
   logic [41:0] exp_seg;
   logic        exp_blank;
   bit          dim_pass;
`ifdef BLINK_BLANKER_DIM_EN
   int          m_dim;
`endif

   task automatic model_reset();
      m_active = 0; m_age = 0; m_pos = 2'd0;
      exp_seg = '0; exp_blank = 1'b0; dim_pass = 0;
`ifdef BLINK_BLANKER_DIM_EN
      m_dim = 0;
`endif
   endtask

   task automatic tick();
      logic [41:0] pmask;
      bit off;
      @(posedge blink_clk);
      if (rst_n) begin
         dim_pass = 0;
`ifdef BLINK_BLANKER_DIM_EN
         dim_pass = ((m_dim % 4) == 0);
         m_dim++;
`endif
         if (!bus.blink || bus.setting_position == 2'd3) m_active = 0;
         else if (!m_active) begin m_active = 1; m_age = 0; end
         else if (bus.setting_position != m_pos) m_age = 0;
         else m_age++;
         m_pos = bus.setting_position;
         off = m_active && (((m_age / int'(HP)) % 2) == 1);
         exp_blank = off;
         exp_seg = bus.i_seg;
         pmask = PAIR1 << (14 * int'(bus.setting_position));
         if (off && !dim_pass) exp_seg = exp_seg & ~pmask;
      end
      #1;
   endtask

   task automatic go_idle();
      bus.blink = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.blink = 1'b0; bus.setting_position = 2'd0; bus.i_seg = ALL1;
      model_reset();
      repeat (2) @(posedge blink_clk);
      #1;
      total++; if (bus.o_seg !== 42'd0) begin bad++; $display("FAIL reset_seg got=%h exp=0", bus.o_seg); end
      total++; if (bus.o_blank !== 1'b0) begin bad++; $display("FAIL reset_blank got=%b exp=0", bus.o_blank); end
      @(negedge blink_clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_passthrough();
      bus.blink = 1'b0; bus.setting_position = 2'd1; bus.i_seg = 42'h2AA_AAAA_AAAA;
      tick();
      total++; if (bus.o_seg !== 42'h2AA_AAAA_AAAA) begin bad++; $display("FAIL pass_seg got=%h exp=2aaaaaaaaaa", bus.o_seg); end
      total++; if (bus.o_blank !== 1'b0) begin bad++; $display("FAIL pass_blank got=%b exp=0", bus.o_blank); end
   endtask

   task automatic test_blink_run();
      logic [13:0] exp_pair;
      bit in_off;
      go_idle();
      bus.blink = 1'b1; bus.setting_position = 2'd1; bus.i_seg = ALL1;
      for (int i = 0; i < 34; i++) begin
         tick();
         in_off = (i >= 8 && i <= 15) || (i >= 24 && i <= 31);
         exp_pair = (in_off && !dim_pass) ? 14'h0 : 14'h3FFF;
         total++; if (bus.o_seg[27:14] !== exp_pair) begin bad++; $display("FAIL run_pair cyc=%0d got=%h exp=%h", i, bus.o_seg[27:14], exp_pair); end
         total++; if ({bus.o_seg[41:28], bus.o_seg[13:0]} !== 28'hFFF_FFFF) begin bad++; $display("FAIL run_other cyc=%0d got=%h exp=fffffff", i, {bus.o_seg[41:28], bus.o_seg[13:0]}); end
         total++; if (bus.o_blank !== in_off) begin bad++; $display("FAIL run_blank cyc=%0d got=%b exp=%b", i, bus.o_blank, in_off); end
      end
   endtask

   task automatic test_pos_change();
      logic [13:0] exp_pair;
      go_idle();
      bus.blink = 1'b1; bus.setting_position = 2'd1; bus.i_seg = ALL1;
      for (int i = 0; i < 12; i++) tick();
      total++; if (bus.o_blank !== 1'b1) begin bad++; $display("FAIL pc_pre_blank got=%b exp=1", bus.o_blank); end
      bus.setting_position = 2'd2;
      tick();
      total++; if (bus.o_blank !== 1'b0) begin bad++; $display("FAIL pc_on_blank got=%b exp=0", bus.o_blank); end
      total++; if (bus.o_seg !== ALL1) begin bad++; $display("FAIL pc_on_seg got=%h exp=%h", bus.o_seg, ALL1); end
      for (int j = 1; j <= 8; j++) begin
         tick();
         total++; if (bus.o_blank !== (j == 8)) begin bad++; $display("FAIL pc_blank j=%0d got=%b exp=%b", j, bus.o_blank, (j == 8)); end
      end
      exp_pair = dim_pass ? 14'h3FFF : 14'h0;
      total++; if (bus.o_seg[41:28] !== exp_pair) begin bad++; $display("FAIL pc_hours got=%h exp=%h", bus.o_seg[41:28], exp_pair); end
      total++; if (bus.o_seg[27:0] !== 28'hFFF_FFFF) begin bad++; $display("FAIL pc_low got=%h exp=fffffff", bus.o_seg[27:0]); end
   endtask

   task automatic test_blink_drop();
      logic [41:0] v;
      go_idle();
      bus.blink = 1'b1; bus.setting_position = 2'd0; bus.i_seg = ALL1;
      for (int i = 0; i < 13; i++) tick();
      total++; if (bus.o_blank !== 1'b1) begin bad++; $display("FAIL drop_pre_blank got=%b exp=1", bus.o_blank); end
      v = {10'($urandom), 32'($urandom)};
      bus.blink = 1'b0; bus.i_seg = v;
      tick();
      total++; if (bus.o_blank !== 1'b0) begin bad++; $display("FAIL drop_blank got=%b exp=0", bus.o_blank); end
      total++; if (bus.o_seg !== v) begin bad++; $display("FAIL drop_seg got=%h exp=%h", bus.o_seg, v); end
      bus.blink = 1'b1; bus.i_seg = ALL1;
      for (int j = 0; j <= 8; j++) begin
         tick();
         total++; if (bus.o_blank !== (j == 8)) begin bad++; $display("FAIL rearm_blank j=%0d got=%b exp=%b", j, bus.o_blank, (j == 8)); end
      end
   endtask

   task automatic test_pos_none();
      logic [41:0] v;
      bus.blink = 1'b1; bus.setting_position = 2'd3;
      for (int i = 0; i < 40; i++) begin
         v = {10'($urandom), 32'($urandom)};
         bus.i_seg = v;
         tick();
         total++; if (bus.o_seg !== v || bus.o_blank !== 1'b0) begin bad++; $display("FAIL none cyc=%0d got=%h/%b exp=%h/0", i, bus.o_seg, bus.o_blank, v); end
      end
   endtask

   task automatic test_reset_mid();
      go_idle();
      bus.blink = 1'b1; bus.setting_position = 2'd2; bus.i_seg = ALL1;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      total++; if (bus.o_seg !== 42'd0) begin bad++; $display("FAIL rmid_seg got=%h exp=0", bus.o_seg); end
      total++; if (bus.o_blank !== 1'b0) begin bad++; $display("FAIL rmid_blank got=%b exp=0", bus.o_blank); end
      repeat (2) @(posedge blink_clk);
      @(negedge blink_clk);
      rst_n = 1'b1;
      for (int j = 0; j <= 8; j++) begin
         tick();
         total++; if (bus.o_blank !== (j == 8)) begin bad++; $display("FAIL rmid_after j=%0d got=%b exp=%b", j, bus.o_blank, (j == 8)); end
      end
   endtask

   task automatic test_random();
      bus.blink = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 24) == 0) bus.blink = ~bus.blink;
         if ($urandom_range(0, 29) == 0) bus.setting_position = 2'($urandom_range(0, 3));
         bus.i_seg = {10'($urandom), 32'($urandom)};
         tick();
         total++; if (bus.o_seg !== exp_seg) begin bad++; $display("FAIL rnd_seg cyc=%0d got=%h exp=%h", i, bus.o_seg, exp_seg); end
         total++; if (bus.o_blank !== exp_blank) begin bad++; $display("FAIL rnd_blank cyc=%0d got=%b exp=%b", i, bus.o_blank, exp_blank); end
      end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_blink_run();
      test_pos_change();
      test_blink_drop();
      test_pos_none();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
